rr_bus_arb_4: RTL and testbench
===============================

// Module: rr_bus_arb_4
// PURPOSE
//  Round-robin arbiter sharing one WIDTH-bit 4:1 bus mux among 4 requesters.
//  Handles valid/ready handshakes and locks the grant for a whole packet, until the beat with last=1.
//  Drives the mux select and a registered output stage; sits between requester blocks and one shared sink.
// PARAMETERS
//  WIDTH    8   data bits per requester and output
//  TIMEOUT  15  idle cycles a locked grant may see no valid before forced release (1..255)
// PORTS
//  i_clk        in   1        clock, all state on rising edge
//  i_rst_n      in   1        asynchronous active-low reset
//  i_req_valid  in   4        per-requester beat valid
//  i_req_data   in   4*WIDTH  requester n on bits [n*WIDTH +: WIDTH]
//  i_req_last   in   4        per-requester end-of-packet flag
//  o_req_ready  out  4        per-requester ready (one-hot or zero)
//  o_valid      out  1        output beat valid (registered)
//  o_data       out  WIDTH    output beat data (registered)
//  o_last       out  1        output end-of-packet (registered)
//  o_src        out  2        index of requester that produced the current output beat
//  i_ready      in   1        sink ready
//  o_timeout    out  1        one-cycle pulse on forced release
// BEHAVIOUR
//  Reset (async assert, sync deassert by the system): state=IDLE, ptr=3, grant=0, idle_cnt=0.
//  Reset also clears o_valid=0, o_data=0, o_last=0, o_src=0, o_req_ready=0, o_timeout=0.
//  A packet in flight at reset is dropped; no output beat survives reset.
//  States:
//  - IDLE: o_req_ready=0.
//    If any i_req_valid, the winner is the first valid in order ptr+1, ptr+2, ptr+3, ptr (mod 4).
//    Then grant<=winner and go to BUSY. This arbitration cycle transfers no data.
//  - BUSY: can_load = !o_valid || i_ready.
//    o_req_ready[grant] = can_load; all other bits are 0.
//    xfer = i_req_valid[grant] && o_req_ready[grant].
//    On xfer: o_data/o_last/o_src <= granted lane, o_valid<=1, idle_cnt<=0.
//    If xfer with i_req_last[grant]=1: ptr<=grant, go to IDLE.
//    No xfer and i_req_valid[grant]=0: idle_cnt++.
//    When idle_cnt reaches TIMEOUT-1: o_timeout=1 for one cycle, ptr<=grant, go to IDLE. No partial-packet marker is emitted.
//    No xfer because the output is stalled (valid=1, ready=0): idle_cnt is held, never incremented.
//  Output stage: if i_ready && o_valid and there is no new xfer, o_valid<=0.
//  Data, last and src hold while o_valid && !i_ready.
//  Latency: valid at cycle 0 in IDLE -> ready at cycle 1 -> o_valid at cycle 2.
//  Back-to-back beats in BUSY have full throughput (1 beat/cycle with i_ready=1).
//  Gap between packets: 1 arbitration cycle.
//  Simultaneous events:
//  - The last beat transferring in the same cycle as new requests: the new winner is picked next cycle with the updated ptr.
//  - The output draining in the same cycle as a load: the load wins and o_valid stays 1.
//  - Requests on non-granted lanes never affect BUSY.
//  i_req_valid deasserting mid-packet is legal: the grant is held until last or timeout.
//  Single-beat packet (last on first beat) is legal.
//  o_req_ready must never have more than one bit set and must never assert in IDLE.
// STRUCTURE
//  Shared package: state enum {IDLE, BUSY}, NUM_REQ=4, sel width 2.
//  Sub-module rr_pick4 (combinational): inputs req[3:0] and ptr[1:0]; outputs winner[1:0] and any.
//  The mux of i_req_data by grant is inline behavioural RTL.
// TESTING
//  1. Reset: hold i_rst_n=0 with all valid=1 -> all outputs 0. Release: first grant goes to req0 (ptr=3).
//  2. All four valid with 1-beat packets, i_ready=1 -> o_src sequence 0,1,2,3,0.
//     Each beat is 2 cycles apart; data matches lane (0xA0+n).
//  3. req2 sends a 3-beat packet (0x11, 0x22, 0x33 with last) while req0 and req1 stay valid.
//     -> o_src=2 for 3 consecutive beats, then grant goes to req0.
//  4. Backpressure: i_ready=0 for 5 cycles mid-packet -> o_data holds, o_req_ready=0.
//     o_timeout stays 0; the stream resumes losslessly when i_ready=1.
//  5. Timeout: req1 sends 1 beat without last, then valid=0, with TIMEOUT=15.
//     -> o_timeout pulses 15 cycles after the beat, and req3 (pending) is granted next.
//  6. Async reset asserted mid-packet between clock edges -> outputs clear immediately.
//     After release, arbitration restarts from req0.

Source files
------------

// File: rtl/rr_bus_arb_4_pkg.sv
// rr_bus_arb_4_pkg: shared types and sizes for the 4-way round-robin bus arbiter
package rr_bus_arb_4_pkg;
    localparam int NUM_REQ = 4;
    localparam int SEL_W = 2;
    typedef enum logic {IDLE, BUSY} state_t;
    typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: picks the first active request after ptr, wrapping so ptr itself is checked last
module rr_pick4
    import rr_bus_arb_4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  sel_t               ptr,
    output sel_t               winner,
    output logic               any
);
    always_comb begin
        winner = ptr;
        any = |req;
        // walk from lowest to highest priority so the nearest requester overwrites last
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[ptr + sel_t'(k + 1)]) winner = ptr + sel_t'(k + 1);
    end
endmodule

// File: rtl/rr_bus_arb_4.sv
// rr_bus_arb_4: round-robin packet arbiter driving one registered WIDTH-bit output stage
module rr_bus_arb_4
    import rr_bus_arb_4_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]       i_req_last,
    output logic [NUM_REQ-1:0]       o_req_ready,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_last,
    output sel_t                     o_src,
    input  logic                     i_ready,
    output logic                     o_timeout
);
    state_t           state;
    sel_t             ptr, grant, winner;
    logic             any, can_load, xfer, lane_valid, lane_last;
    logic [WIDTH-1:0] lane_data;
    logic [7:0]       idle_cnt;

    rr_pick4 u_pick (.req(i_req_valid), .ptr(ptr), .winner(winner), .any(any));

    always_comb begin
        lane_data = i_req_data[grant*WIDTH +: WIDTH];
        lane_valid = i_req_valid[grant];
        lane_last = i_req_last[grant];
        can_load = !o_valid || i_ready;
        o_req_ready = (state == BUSY && can_load) ? NUM_REQ'(1) << grant : '0;
        xfer = lane_valid && o_req_ready[grant];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            ptr <= sel_t'(NUM_REQ - 1);
            grant <= '0;
            idle_cnt <= '0;
            o_valid <= 1'b0;
            o_data <= '0;
            o_last <= 1'b0;
            o_src <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= 1'b0;
            if (xfer) begin
                o_data <= lane_data;
                o_last <= lane_last;
                o_src <= grant;
                o_valid <= 1'b1;
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
            if (state == IDLE) begin
                if (any) begin
                    grant <= winner;
                    idle_cnt <= '0;
                    state <= BUSY;
                end
            end else if (xfer) begin
                idle_cnt <= '0;
                if (lane_last) begin
                    ptr <= grant;
                    state <= IDLE;
                end
            end else if (!lane_valid && can_load) begin
                // a stalled sink holds the count; only a silent requester ages the lock
                if (idle_cnt == 8'(TIMEOUT - 1)) begin
                    o_timeout <= 1'b1;
                    ptr <= grant;
                    idle_cnt <= '0;
                    state <= IDLE;
                end else begin
                    idle_cnt <= idle_cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rr_bus_arb_4.sv
// tb_rr_bus_arb_4: directed checks of arbitration order, packet lock, backpressure, timeout and reset
module tb_rr_bus_arb_4;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = 4'b1111;
    logic [31:0] req_data = 32'hA3A2A1A0;
    logic [3:0]  req_last = 4'b1111;
    logic [3:0]  req_ready;
    logic        out_valid, out_last, timeout, ready = 1'b1;
    logic [7:0]  out_data;
    logic [1:0]  src;
    int          checks = 0, failures = 0;

    rr_bus_arb_4 #(.WIDTH(8), .TIMEOUT(15)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_data(req_data),
        .i_req_last(req_last), .o_req_ready(req_ready), .o_valid(out_valid), .o_data(out_data),
        .o_last(out_last), .o_src(src), .i_ready(ready), .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_beat(input string tag, input logic [1:0] s, input logic [7:0] d, input logic l);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_src"}, 32'(src), 32'(s));
        chk({tag, "_data"}, 32'(out_data), 32'(d));
        chk({tag, "_last"}, 32'(out_last), 32'(l));
    endtask

    task automatic chk_clear(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_last"}, 32'(out_last), 32'd0);
        chk({tag, "_src"}, 32'(src), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        chk_clear("rst");
        rst_n = 1'b1;
        // round robin over four single-beat packets, starting at req0
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_gap_valid", 32'(out_valid), 32'd0);
            chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (i % 4)));
            tick();
            chk_beat("rr_beat", 2'(i % 4), 8'hA0 + 8'(i % 4), 1'b1);
        end
        // single beat from req1 moves ptr to 1
        req_valid = 4'b0010;
        tick();
        tick();
        chk_beat("pre_beat", 2'd1, 8'hA1, 1'b1);
        // req2 three-beat packet with req0/req1 contending
        req_valid = 4'b0111;
        req_data[16 +: 8] = 8'h11;
        req_last = 4'b1011;
        tick();
        chk("pkt_grant", 32'(req_ready), 32'b0100);
        tick();
        chk_beat("pkt_b0", 2'd2, 8'h11, 1'b0);
        req_data[16 +: 8] = 8'h22;
        tick();
        chk_beat("pkt_b1", 2'd2, 8'h22, 1'b0);
        req_data[16 +: 8] = 8'h33;
        req_last = 4'b1111;
        tick();
        chk_beat("pkt_b2", 2'd2, 8'h33, 1'b1);
        req_valid = 4'b0011;
        tick();
        chk("pkt_next", 32'(req_ready), 32'b0001);
        // backpressure mid-packet on req0
        req_valid = 4'b0001;
        req_data[0 +: 8] = 8'h40;
        req_last = 4'b1110;
        tick();
        chk_beat("bp_b0", 2'd0, 8'h40, 1'b0);
        req_data[0 +: 8] = 8'h41;
        ready = 1'b0;
        #1;
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_data", 32'(out_data), 32'h40);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_timeout", 32'(timeout), 32'd0);
        end
        ready = 1'b1;
        tick();
        chk_beat("bp_b1", 2'd0, 8'h41, 1'b0);
        req_data[0 +: 8] = 8'h42;
        req_last = 4'b1111;
        tick();
        chk_beat("bp_b2", 2'd0, 8'h42, 1'b1);
        // req1 stops mid-packet; req3 waits for the forced release
        req_valid = 4'b0010;
        req_data[8 +: 8] = 8'h51;
        req_last = 4'b1101;
        tick();
        chk("to_grant", 32'(req_ready), 32'b0010);
        tick();
        chk_beat("to_beat", 2'd1, 8'h51, 1'b0);
        req_valid = 4'b1000;
        req_last = 4'b1111;
        for (int i = 1; i < 15; i++) begin
            tick();
            chk("to_early", 32'(timeout), 32'd0);
        end
        tick();
        chk("to_pulse", 32'(timeout), 32'd1);
        tick();
        chk("to_pulse_end", 32'(timeout), 32'd0);
        chk("to_next", 32'(req_ready), 32'b1000);
        tick();
        chk_beat("to_r3", 2'd3, 8'hA3, 1'b1);
        // async reset in the middle of a req2 packet
        req_valid = 4'b0100;
        req_data[16 +: 8] = 8'h61;
        req_last = 4'b1011;
        tick();
        tick();
        chk_beat("ar_beat", 2'd2, 8'h61, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_clear("ar");
        req_valid = 4'b1111;
        req_data = 32'hA3A2A1A0;
        req_last = 4'b1111;
        tick();
        chk_clear("ar_hold");
        rst_n = 1'b1;
        tick();
        chk("ar_restart", 32'(req_ready), 32'b0001);
        tick();
        chk_beat("ar_r0", 2'd0, 8'hA0, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
